display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Scan scheduler for the multiplexed 7-segment display of the calculator.
//  Holds N_DIGITS hex values and decodes each one to segments. Builds one
//  16-bit frame per digit and shifts it MSB-first over the sclk/cs/sdo link,
//  then pulses the digit-latch clock. Cycles through all digits forever.
//  Sits between the calculator core (digit values) and the board GPIO shift
//  registers, and replaces free-running load pulses with a sequenced scan.
// PARAMETERS
//  N_DIGITS  4    number of scanned digits (1..8); select byte is one-hot
//  SCLK_DIV  256  clk cycles per sclk half-period (>=1)
//  GAP_BITS  2    idle sclk periods after each latch before the next frame
// PORTS
//  clk        in   1           system clock (HFOSC)
//  rst        in   1           async active-high reset
//  digits_in  in   4*N_DIGITS  hex value per digit; digit i = [4i+3:4i]
//  dp_in      in   N_DIGITS    decimal point per digit, 1 = lit
//  blank_in   in   N_DIGITS    1 = digit dark (segment byte forced 8'h00)
//  update     in   1           1-clk strobe: capture digits/dp/blank inputs
//  sclk       out  1           serial clock, idle low
//  cs         out  1           data enable, high while frame bits shift
//  sdo        out  1           serial data, changes on sclk falling edge
//  dclk       out  1           digit latch pulse, high for one sclk period
//  busy       out  1           high whenever FSM is not in IDLE
// BEHAVIOUR
//  Reset: sclk=0, cs=0, sdo=0, dclk=0, busy=0, digit index=0, shadow=0.
//   The tick counter clears and the FSM goes to IDLE. Reset mid-frame
//   aborts immediately. No partial latch pulse may follow release.
//  Tick: counter runs 0..SCLK_DIV-1 and tick=1 at SCLK_DIV-1. Every
//   FSM/sclk action occurs only on tick. One bit = 2 ticks.
//  Frame = {seg[7:0], sel[7:0]}; seg = {dp,g,f,e,d,c,b,a} active-high.
//   sel = 1<<idx, active-high. Hex map: 0=3F 1=06 2=5B 3=4F 4=66 5=6D
//   6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//  FSM (transitions on tick):
//   IDLE  -> LOAD on the first tick after reset.
//   LOAD  : shift reg <= frame(idx); bit cnt=15; cs<=1; sdo<=frame[15]
//           -> SHIFT.
//   SHIFT : alternate ticks raise sclk (data sampled) and lower sclk.
//           On the fall, sdo <= next bit. After the rise of bit 0, the
//           next tick lowers sclk, sets cs<=0 and dclk<=1 -> LATCH.
//   LATCH : dclk stays high 2 ticks, then dclk<=0 -> GAP.
//   GAP   : 2*GAP_BITS ticks idle. Then idx <= (idx==N_DIGITS-1)?0:idx+1
//           -> LOAD.
//  Frame timing: one frame = 2*(16+1+GAP_BITS)+1 ticks (LOAD incl.).
//  Shadow regs: update sets a pending flag and captures inputs into a
//   staging reg. Staging copies into shadow only when idx wraps to 0
//   (GAP->LOAD with next idx 0), so a scan never mixes old/new values.
//   update during pending overwrites staging; the last value wins.
//   update on the same clk as the copy -> the new values go to staging
//   and pending stays set.
//  Invariant: dclk and cs never both high. sclk=0 whenever cs=0.
// STRUCTURE
//  display_pkg.vh: state encodings (IDLE/LOAD/SHIFT/LATCH/GAP), FRAME_W=16,
//   SEG_* constants for the hex map.
//  Sub-module hex_to_seg7 (combinational 4b -> 7b, plus dp merge outside).
//  Tick divider, FSM, shift reg and shadow/staging regs live in the top.
// TESTING (bench: N_DIGITS=4, SCLK_DIV=2, GAP_BITS=2)
//  Reset, then update digits=16'h3210, dp=0, blank=0 -> the first four
//   frames are 16'h3F01, 16'h0602, 16'h5B04, 16'h4F08. Then repeat.
//  digits=16'hFEDC, dp=4'b0101 -> frames C=B901, d=5E02, E=F904, F=7108.
//  Assert update mid-scan at idx=2 with new values -> frames for idx 2,3
//   stay old. The new values appear from the next idx 0. Two updates
//   before the wrap -> only the second value is shown.
//  blank=4'b1111 -> every segment byte is 00. Select bytes still walk
//   01,02,04,08, and the dclk pulse count = frame count.
//  Assert rst during SHIFT bit 7 -> within 1 clk sclk=cs=sdo=dclk=busy=0.
//   After release the first frame is idx 0 with the full 16 bits.
//  Protocol checker over 1000 frames: 16 sclk rises per cs window.
//   sdo is stable while sclk is high. dclk is high for exactly 2 ticks
//   after cs falls, and cs&dclk never both high.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment display scan controller.
// Segment constants are active-high {g,f,e,d,c,b,a}.
package display_scan_ctrl_pkg;

    localparam int unsigned FRAME_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StLatch,
        StGap
    } scan_state_e;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    function automatic logic [7:0] sel_onehot(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_hex_to_seg7.sv
// Combinational hex digit to 7-segment decoder (active-high, no decimal point).
module display_scan_ctrl_hex_to_seg7
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_0;
        unique case (i_hex)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan scheduler for a multiplexed 7-segment display: shifts one {seg, sel} frame
// per digit over sclk/cs/sdo, pulses dclk, and cycles through all digits forever.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned SCLK_DIV = 256,
    parameter int unsigned GAP_BITS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*N_DIGITS-1:0] i_digits,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic [N_DIGITS-1:0]   i_blank,
    input  logic                  i_update,
    output logic                  o_sclk,
    output logic                  o_cs,
    output logic                  o_sdo,
    output logic                  o_dclk,
    output logic                  o_busy
);

    localparam int unsigned IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned DIV_W     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned GAP_TICKS = 2 * GAP_BITS;
    localparam int unsigned GAP_LAST  = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
    localparam int unsigned WAIT_W    = $clog2(GAP_TICKS + 2);
    localparam int unsigned DIG_W     = 4 * N_DIGITS;

    logic [DIV_W-1:0]   r_div_cnt;
    logic               w_tick;
    scan_state_e        r_state, w_state_nxt;
    logic [FRAME_W-1:0] r_shift, w_shift_nxt;
    logic [3:0]         r_bit_cnt, w_bit_cnt_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt, w_wait_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt, w_idx_inc;
    logic               r_sclk, w_sclk_nxt;
    logic               r_cs, w_cs_nxt;
    logic               r_sdo, w_sdo_nxt;
    logic               r_dclk, w_dclk_nxt;
    logic               w_idx_last, w_wrap;

    logic [DIG_W-1:0]    r_stage_digits, r_shadow_digits;
    logic [N_DIGITS-1:0] r_stage_dp, r_shadow_dp;
    logic [N_DIGITS-1:0] r_stage_blank, r_shadow_blank;
    logic                r_pending;

    logic [3:0]         w_cur_hex;
    logic               w_cur_dp, w_cur_blank;
    logic [6:0]         w_seg7;
    logic [7:0]         w_seg_byte;
    logic [FRAME_W-1:0] w_frame;

    assign w_tick = (r_div_cnt == DIV_W'(SCLK_DIV - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_comb begin
        w_cur_hex   = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_cur_hex   = r_shadow_digits[4*i +: 4];
                w_cur_dp    = r_shadow_dp[i];
                w_cur_blank = r_shadow_blank[i];
            end
        end
    end

    display_scan_ctrl_hex_to_seg7 u_hex_to_seg7 (
        .i_hex (w_cur_hex),
        .o_seg (w_seg7)
    );

    assign w_seg_byte = w_cur_blank ? 8'h00 : {w_cur_dp, w_seg7};
    assign w_frame    = {w_seg_byte, sel_onehot(3'(r_idx))};
    assign w_idx_last = (r_idx == IDX_W'(N_DIGITS - 1));
    assign w_idx_inc  = w_idx_last ? '0 : r_idx + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_idx      <= '0;
            r_sclk     <= 1'b0;
            r_cs       <= 1'b0;
            r_sdo      <= 1'b0;
            r_dclk     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_idx      <= w_idx_nxt;
            r_sclk     <= w_sclk_nxt;
            r_cs       <= w_cs_nxt;
            r_sdo      <= w_sdo_nxt;
            r_dclk     <= w_dclk_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_wait_nxt    = r_wait_cnt;
        w_idx_nxt     = r_idx;
        w_sclk_nxt    = r_sclk;
        w_cs_nxt      = r_cs;
        w_sdo_nxt     = r_sdo;
        w_dclk_nxt    = r_dclk;
        w_wrap        = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                StIdle: w_state_nxt = StLoad;
                StLoad: begin
                    w_shift_nxt   = w_frame;
                    w_bit_cnt_nxt = 4'(FRAME_W - 1);
                    w_cs_nxt      = 1'b1;
                    w_sdo_nxt     = w_frame[FRAME_W-1];
                    w_state_nxt   = StShift;
                end
                StShift: begin
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        w_sclk_nxt = 1'b0;
                        if (r_bit_cnt == 4'd0) begin
                            // cs drops on the same edge dclk rises, so the two never overlap
                            w_cs_nxt    = 1'b0;
                            w_sdo_nxt   = 1'b0;
                            w_dclk_nxt  = 1'b1;
                            w_wait_nxt  = '0;
                            w_state_nxt = StLatch;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                            w_shift_nxt   = {r_shift[FRAME_W-2:0], 1'b0};
                            w_sdo_nxt     = r_shift[FRAME_W-2];
                        end
                    end
                end
                StLatch: begin
                    if (r_wait_cnt == WAIT_W'(1)) begin
                        w_dclk_nxt = 1'b0;
                        w_wait_nxt = '0;
                        if (GAP_TICKS == 0) begin
                            w_idx_nxt   = w_idx_inc;
                            w_wrap      = w_idx_last;
                            w_state_nxt = StLoad;
                        end else begin
                            w_state_nxt = StGap;
                        end
                    end else begin
                        w_wait_nxt = r_wait_cnt + 1'b1;
                    end
                end
                StGap: begin
                    if (r_wait_cnt == WAIT_W'(GAP_LAST)) begin
                        w_idx_nxt   = w_idx_inc;
                        w_wrap      = w_idx_last;
                        w_state_nxt = StLoad;
                    end else begin
                        w_wait_nxt = r_wait_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // Shadow only changes at the wrap to digit 0, so one scan never mixes old and new values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stage_digits  <= '0;
            r_stage_dp      <= '0;
            r_stage_blank   <= '0;
            r_shadow_digits <= '0;
            r_shadow_dp     <= '0;
            r_shadow_blank  <= '0;
            r_pending       <= 1'b0;
        end else begin
            if (w_wrap && r_pending) begin
                r_shadow_digits <= r_stage_digits;
                r_shadow_dp     <= r_stage_dp;
                r_shadow_blank  <= r_stage_blank;
            end
            if (i_update) begin
                r_stage_digits <= i_digits;
                r_stage_dp     <= i_dp;
                r_stage_blank  <= i_blank;
                r_pending      <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_sclk = r_sclk;
    assign o_cs   = r_cs;
    assign o_sdo  = r_sdo;
    assign o_dclk = r_dclk;
    assign o_busy = (r_state != StIdle);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a frame-level reference model pushes expected
// frames; a negedge monitor deserialises the link, checks protocol and pops/compares.
module tb_display_scan_ctrl;

    localparam int unsigned N_DIGITS    = 4;
    localparam int unsigned SCLK_DIV    = 2;
    localparam int unsigned GAP_BITS    = 2;
    localparam int          FRAME_TICKS = 2 * (16 + 1 + GAP_BITS) + 1;
    localparam int          FRAME_EDGES = FRAME_TICKS * SCLK_DIV;
    localparam int          SCAN_EDGES  = FRAME_EDGES * N_DIGITS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic        update = 1'b0;
    logic        sclk, cs, sdo, dclk, busy;

    display_scan_ctrl #(
        .N_DIGITS (N_DIGITS),
        .SCLK_DIV (SCLK_DIV),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_digits (digits),
        .i_dp     (dp),
        .i_blank  (blank),
        .i_update (update),
        .o_sclk   (sclk),
        .o_cs     (cs),
        .o_sdo    (sdo),
        .o_dclk   (dclk),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Index of the next posedge since reset release.
    int edge_n = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          upd_edge [$];
    logic [23:0] upd_val [$];
    logic [15:0] exp_q [$];
    int          next_f = 0;

    int          frames_obs = 0;
    int          dclk_rises = 0;
    int          mon_bits = 0;
    int          viol = 0;
    int          dclk_len = 0;
    logic [15:0] sh = '0;
    logic        p_sclk = 1'b0, p_cs = 1'b0, p_dclk = 1'b0, p_sdo = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Frame f of a run: scan s = f/N. Shadow for scan s>0 holds the last update that
    // landed strictly before the GAP->LOAD edge that starts scan s; scan 0 shows zeros.
    function automatic logic [15:0] exp_frame(input int f);
        int          s = f / N_DIGITS;
        int          idx = f % N_DIGITS;
        logic [23:0] v = '0;
        logic [15:0] d;
        logic [3:0]  p, b;
        logic [7:0]  seg, sel;
        if (s > 0) begin
            for (int k = 0; k < upd_edge.size(); k++) begin
                if (upd_edge[k] < SCAN_EDGES * s + 1) v = upd_val[k];
            end
        end
        {d, p, b} = v;
        seg = b[idx] ? 8'h00 : {p[idx], seg_tab[d[4*idx +: 4]]};
        sel = 8'h01 << idx;
        return {seg, sel};
    endfunction

    initial begin : model
        forever begin
            @(negedge clk);
            if (!rst && edge_n == FRAME_EDGES * next_f + 3) begin
                exp_q.push_back(exp_frame(next_f));
                next_f++;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                p_sclk = 1'b0; p_cs = 1'b0; p_dclk = 1'b0; p_sdo = 1'b0;
                mon_bits = 0; viol = 0; dclk_len = 0; sh = '0;
            end else begin
                if (cs && dclk) viol++;
                if (!cs && sclk) viol++;
                if (p_sclk && sclk && (sdo != p_sdo)) viol++;
                if (!p_cs && cs) begin
                    mon_bits = 0;
                    sh = '0;
                    check("cs_rise_time", (edge_n - 4) % FRAME_EDGES, 0);
                    check("busy_in_frame", busy, 1);
                end
                if (!p_sclk && sclk && cs) begin
                    sh = {sh[14:0], sdo};
                    mon_bits++;
                end
                if (p_cs && !cs) begin
                    check("bit_count", mon_bits, 16);
                    check("dclk_at_cs_fall", dclk, 1);
                    check("protocol", viol, 0);
                    viol = 0;
                    if (exp_q.size() == 0) check("frame_unexpected", sh, 32'hFFFF_FFFF);
                    else check("frame", sh, exp_q.pop_front());
                    frames_obs++;
                end
                if (!p_dclk && dclk) begin
                    dclk_len = 0;
                    dclk_rises++;
                end
                if (dclk) dclk_len++;
                if (p_dclk && !dclk) check("dclk_len", dclk_len, 2 * SCLK_DIV);
                p_sclk = sclk; p_cs = cs; p_dclk = dclk; p_sdo = sdo;
            end
        end
    end

    // Called at a negedge; the strobe is seen by posedge edge_n.
    task automatic do_update(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        digits = d; dp = p; blank = b; update = 1'b1;
        upd_edge.push_back(edge_n);
        upd_val.push_back({d, p, b});
        @(negedge clk);
        update = 1'b0;
        digits = 16'($urandom); dp = 4'($urandom); blank = 4'($urandom);
    endtask

    task automatic wait_frames(input int n);
        int target = frames_obs + n;
        int budget = n * FRAME_EDGES + 400;
        while (frames_obs < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (frames_obs < target) check("frame_timeout", frames_obs, target);
    endtask

    task automatic wait_edge(input int t);
        int budget = t - edge_n + 10;
        while (edge_n != t && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (edge_n != t) check("edge_timeout", edge_n, t);
    endtask

    task automatic apply_reset(input int hold);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_outputs", {sclk, cs, sdo, dclk, busy}, 5'b0);
        exp_q.delete();
        upd_edge.delete();
        upd_val.delete();
        next_f = 0;
        repeat (hold) @(negedge clk);
        check("reset_hold_outputs", {sclk, cs, sdo, dclk, busy}, 5'b0);
        rst = 1'b0;
    endtask

    initial begin : stimulus
        int s;
        int budget;
        apply_reset(3);
        @(negedge clk);
        check("idle_after_release", {sclk, cs, sdo, dclk, busy}, 5'b0);

        // Scan 0 shows reset shadow; the update takes effect from scan 1.
        do_update(16'h3210, 4'b0000, 4'b0000);
        wait_frames(8);
        do_update(16'hFEDC, 4'b0101, 4'b0000);
        wait_frames(8);

        // Update on the exact copy edge must be deferred to the following scan.
        s = edge_n / SCAN_EDGES + 1;
        wait_edge(SCAN_EDGES * s + 1);
        do_update(16'h9876, 4'b1000, 4'b0000);
        wait_frames(9);

        // Two updates mid-scan at idx 2: only the second shows, from the next idx 0.
        s = edge_n / SCAN_EDGES + 1;
        wait_edge(SCAN_EDGES * s + 2 * FRAME_EDGES + 23);
        do_update(16'hABCD, 4'b0011, 4'b0000);
        repeat (30) @(negedge clk);
        do_update(16'h5A5A, 4'b1100, 4'b0010);
        wait_frames(10);

        do_update(16'($urandom), 4'($urandom), 4'b1111);
        wait_frames(9);

        repeat (40) begin
            repeat ($urandom_range(1, 300)) @(negedge clk);
            do_update(16'($urandom), 4'($urandom), 4'($urandom));
        end
        wait_frames(5);

        // Abort mid-frame while bit 7 is on the line.
        budget = 2 * FRAME_EDGES;
        while (!(cs && mon_bits == 8) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("reached_bit7", mon_bits, 8);
        apply_reset(4);
        do_update(16'($urandom), 4'($urandom), 4'($urandom));
        wait_frames(12);

        repeat (8) begin
            do_update(16'($urandom), 4'($urandom), 4'($urandom));
            wait_frames(50);
        end

        check("dclk_pulses_vs_frames", dclk_rises, frames_obs);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
